// File: rtl/interrupt_controller_pkg.sv
// ----------------------------------------------------------------------------
// interrupt_controller_pkg
// Types and constants shared by the interrupt controller and its priority
// encoder: source numbering, vector layout and the dispatch FSM state type.
// ----------------------------------------------------------------------------
package interrupt_controller_pkg;

    localparam int NUM_SRC = 5;

    // Lower number = higher priority; the number also selects the vector slot.
    typedef enum logic [2:0] {
        VBLANK = 3'd0,
        LCDC   = 3'd1,
        TIMER  = 3'd2,
        SERIAL = 3'd3,
        JOYPAD = 3'd4
    } int_src_t;

    localparam logic [15:0] INT_VEC_BASE   = 16'h0040;
    localparam logic [15:0] INT_VEC_STRIDE = 16'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_CLEAR = 2'd2
    } intc_state_t;

    // ISR entry address of a source: 0x40, 0x48, 0x50, 0x58, 0x60.
    function automatic logic [15:0] vector_of(input int_src_t src);
        return INT_VEC_BASE + INT_VEC_STRIDE * {13'd0, src};
    endfunction

endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// ----------------------------------------------------------------------------
// int_prio_enc
// Fixed-priority encoder over the five interrupt sources; bit 0 (vblank)
// has the highest priority.
//   req   : pending source bits
//   valid : at least one bit of req is set
//   index : number of the lowest set bit (VBLANK when req is zero)
// ----------------------------------------------------------------------------
module int_prio_enc
    import interrupt_controller_pkg::*;
(
    input  logic [4:0] req,
    output logic       valid,
    output int_src_t   index
);

    always_comb begin
        valid = |req;
        index = VBLANK;
        // Walk from the lowest priority upward so the lowest set bit wins.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = int_src_t'(i[2:0]);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// ----------------------------------------------------------------------------
// interrupt_controller
// Game-Boy style interrupt controller: IF/IE registers, IME with the EI
// one-instruction delay, priority selection and a three-state dispatch
// handshake with the CPU.
//   clk            : system clock
//   rst            : asynchronous active-low reset, released synchronously
//   src_req        : one-cycle request pulses {joypad,serial,timer,lcdc,vblank}
//   if_wr/if_wdata : CPU write of IF
//   ie_wr/ie_wdata : CPU write of IE
//   if_q, ie_q     : register read-back ({3'b111, IF} and IE)
//   ime_set/ime_clr/reti : EI, DI and RETI executed
//   instr_boundary : pulse at the end of each CPU instruction
//   int_req/int_vector/int_ack : dispatch request, ISR address, CPU accept
//   int_clear      : one-cycle pulse after the serviced IF bit is cleared
//   wake           : HALT exit condition (any enabled request pending)
//   ime_q          : current IME
// ----------------------------------------------------------------------------
module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  src_req,
    input  logic        if_wr,
    input  logic [4:0]  if_wdata,
    input  logic        ie_wr,
    input  logic [7:0]  ie_wdata,
    output logic [7:0]  if_q,
    output logic [7:0]  ie_q,
    input  logic        ime_set,
    input  logic        ime_clr,
    input  logic        reti,
    input  logic        instr_boundary,
    output logic        int_req,
    output logic [15:0] int_vector,
    input  logic        int_ack,
    output logic        int_clear,
    output logic        wake,
    output logic        ime_q
);

    logic [1:0]  rst_sync;
    logic        rst_int;

    logic [4:0]  if_r, if_nx;
    logic [7:0]  ie_r;
    logic        ime_r, ime_nx;
    logic        ei_pend_r, ei_pend_nx;
    intc_state_t state_r, state_nx;
    int_src_t    idx_r, idx_nx;

    logic [4:0]  pending;
    logic        prio_valid;
    int_src_t    prio_idx;
    logic        ack_fire;

    // Reset asserts immediately but is released two clock edges later, so
    // every flop leaves reset on the same clean edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int = rst_sync[1];

    assign pending  = if_r & ie_r[4:0];
    assign ack_fire = (state_r == ST_REQ) && int_ack;

    int_prio_enc u_prio (
        .req   (pending),
        .valid (prio_valid),
        .index (prio_idx)
    );

    // IF: CPU write, then service clear, then new requests on top so a
    // pulse arriving on the same edge is never lost.
    always_comb begin
        if_nx = if_wr ? if_wdata : if_r;
        if (ack_fire) begin
            if_nx[idx_r] = 1'b0;
        end
        if_nx = if_nx | src_req;
    end

    // IME / EI delay: later statements take precedence.
    always_comb begin
        ime_nx     = ime_r;
        ei_pend_nx = ei_pend_r;
        // ei_pend is only visible the cycle after EI, so the boundary that
        // ends the EI instruction itself does not enable interrupts.
        if (ei_pend_r && instr_boundary) begin
            ime_nx     = 1'b1;
            ei_pend_nx = 1'b0;
        end
        if (ime_set) begin
            ei_pend_nx = 1'b1;
        end
        if (reti) begin
            ime_nx = 1'b1;
        end
        if (ime_clr || ack_fire) begin
            ime_nx     = 1'b0;
            ei_pend_nx = 1'b0;
        end
    end

    always_comb begin
        state_nx = state_r;
        idx_nx   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (ime_r && prio_valid && instr_boundary) begin
                    state_nx = ST_REQ;
                    idx_nx   = prio_idx;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_nx = ST_CLEAR;
                end else if (ime_clr) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            if_r      <= 5'd0;
            ie_r      <= 8'd0;
            ime_r     <= 1'b0;
            ei_pend_r <= 1'b0;
            state_r   <= ST_IDLE;
            idx_r     <= VBLANK;
        end else begin
            if_r      <= if_nx;
            if (ie_wr) begin
                ie_r  <= ie_wdata;
            end
            ime_r     <= ime_nx;
            ei_pend_r <= ei_pend_nx;
            state_r   <= state_nx;
            idx_r     <= idx_nx;
        end
    end

    assign if_q       = {3'b111, if_r};
    assign ie_q       = ie_r;
    assign int_req    = (state_r == ST_REQ);
    assign int_clear  = (state_r == ST_CLEAR);
    assign int_vector = vector_of(idx_r);
    assign wake       = |pending;
    assign ime_q      = ime_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// ----------------------------------------------------------------------------
// tb_interrupt_controller
// Directed scenarios followed by random traffic, every cycle compared with
// a behavioural model of the interrupt rules.
// ----------------------------------------------------------------------------
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  src_req = '0;
    logic        if_wr = 1'b0;
    logic [4:0]  if_wdata = '0;
    logic        ie_wr = 1'b0;
    logic [7:0]  ie_wdata = '0;
    logic [7:0]  if_q;
    logic [7:0]  ie_q;
    logic        ime_set = 1'b0;
    logic        ime_clr = 1'b0;
    logic        reti = 1'b0;
    logic        instr_boundary = 1'b0;
    logic        int_req;
    logic [15:0] int_vector;
    logic        int_ack = 1'b0;
    logic        int_clear;
    logic        wake;
    logic        ime_q;

    int n_cmp  = 0;
    int n_fail = 0;

    interrupt_controller dut (
        .clk            (clk),
        .rst            (rst),
        .src_req        (src_req),
        .if_wr          (if_wr),
        .if_wdata       (if_wdata),
        .ie_wr          (ie_wr),
        .ie_wdata       (ie_wdata),
        .if_q           (if_q),
        .ie_q           (ie_q),
        .ime_set        (ime_set),
        .ime_clr        (ime_clr),
        .reti           (reti),
        .instr_boundary (instr_boundary),
        .int_req        (int_req),
        .int_vector     (int_vector),
        .int_ack        (int_ack),
        .int_clear      (int_clear),
        .wake           (wake),
        .ime_q          (ime_q)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = waiting, 1 = requesting CPU, 2 = clearing.
    logic [4:0] m_if;
    logic [7:0] m_ie;
    logic       m_ime;
    logic       m_ei;
    int         m_phase;
    int         m_idx;

    task automatic model_reset();
        m_if = 0; m_ie = 0; m_ime = 0; m_ei = 0; m_phase = 0; m_idx = 0;
    endtask

    task automatic model_edge();
        logic [4:0] pend, n_if;
        logic [7:0] n_ie;
        logic       n_ime, n_ei, acked;
        int         winner, n_phase, n_idx;
        pend   = m_if & m_ie[4:0];
        winner = -1;
        for (int i = 0; i < 5; i++)
            if (pend[i] && winner < 0) winner = i;
        acked = (m_phase == 1) && int_ack;
        n_if  = if_wr ? if_wdata : m_if;
        if (acked) n_if[m_idx] = 1'b0;
        n_if  = n_if | src_req;
        n_ie  = ie_wr ? ie_wdata : m_ie;
        n_ime = m_ime;
        n_ei  = m_ei;
        if (m_ei && instr_boundary) begin n_ime = 1; n_ei = 0; end
        if (ime_set) n_ei = 1;
        if (reti) n_ime = 1;
        if (ime_clr || acked) begin n_ime = 0; n_ei = 0; end
        n_phase = m_phase;
        n_idx   = m_idx;
        if (m_phase == 0) begin
            if (m_ime && winner >= 0 && instr_boundary) begin
                n_phase = 1; n_idx = winner;
            end
        end else if (m_phase == 1) begin
            if (int_ack) n_phase = 2;
            else if (ime_clr) n_phase = 0;
        end else begin
            n_phase = 0;
        end
        m_if = n_if; m_ie = n_ie; m_ime = n_ime; m_ei = n_ei;
        m_phase = n_phase; m_idx = n_idx;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("if_q",       {8'h00, if_q},  {8'h00, 3'b111, m_if});
        check("ie_q",       {8'h00, ie_q},  {8'h00, m_ie});
        check("int_req",    {15'd0, int_req},   {15'd0, (m_phase == 1)});
        check("int_clear",  {15'd0, int_clear}, {15'd0, (m_phase == 2)});
        check("int_vector", int_vector, 16'(64 + 8 * m_idx));
        check("wake",       {15'd0, wake},  {15'd0, |(m_if & m_ie[4:0])});
        check("ime_q",      {15'd0, ime_q}, {15'd0, m_ime});
    endtask

    task automatic idle_inputs();
        src_req = 0; if_wr = 0; if_wdata = 0; ie_wr = 0; ie_wdata = 0;
        ime_set = 0; ime_clr = 0; reti = 0; instr_boundary = 0; int_ack = 0;
    endtask

    // One clock with the currently driven inputs, then compare everything.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
        idle_inputs();
    endtask

    // Clock edge while the design is held in (or leaving) reset.
    task automatic reset_tick();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic release_reset();
        rst = 1'b1;
        reset_tick();
        reset_tick();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #1 rst = 1'b0;
        #1;
        check_model();
        reset_tick();
        check("rst if_q", {8'h00, if_q}, 16'h00E0);
        check("rst vector", int_vector, 16'h0040);
        release_reset();

        // Vblank beats timer; ack clears only the serviced bit.
        ie_wr = 1; ie_wdata = 8'h1F; tick();
        reti = 1; tick();
        src_req = 5'b00101; tick();
        instr_boundary = 1; tick();
        check("vblank req", {15'd0, int_req}, 16'd1);
        check("vblank vec", int_vector, 16'h0040);
        int_ack = 1; tick();
        check("ack if_q", {8'h00, if_q}, 16'h00E4);
        check("ack clear", {15'd0, int_clear}, 16'd1);
        check("ack ime", {15'd0, ime_q}, 16'd0);
        tick();
        check("clear pulse end", {15'd0, int_clear}, 16'd0);

        // EI delay: the boundary of EI itself does not dispatch.
        if_wr = 1; if_wdata = 0; tick();
        src_req = 5'b00100; tick();
        ime_set = 1; tick();
        instr_boundary = 1; tick();
        check("ei no req", {15'd0, int_req}, 16'd0);
        check("ei ime", {15'd0, ime_q}, 16'd1);
        instr_boundary = 1; tick();
        check("timer vec", int_vector, 16'h0050);
        int_ack = 1; tick();
        tick();

        // Latched vector survives a higher-priority arrival.
        reti = 1; tick();
        src_req = 5'b01000; tick();
        instr_boundary = 1; tick();
        check("serial vec", int_vector, 16'h0058);
        src_req = 5'b00001; tick();
        check("serial vec held", int_vector, 16'h0058);
        int_ack = 1; tick();
        check("vblank kept", {8'h00, if_q}, 16'h00E1);
        tick();
        instr_boundary = 1; tick();
        instr_boundary = 1; tick();
        check("no nest", {15'd0, int_req}, 16'd0);
        reti = 1; tick();
        instr_boundary = 1; tick();
        check("after reti", int_vector, 16'h0040);
        int_ack = 1; tick();
        tick();

        // Wake ignores IME.
        ime_clr = 1; tick();
        ie_wr = 1; ie_wdata = 8'h10; tick();
        if_wr = 1; if_wdata = 0; tick();
        src_req = 5'b10000; tick();
        check("wake set", {15'd0, wake}, 16'd1);
        instr_boundary = 1; tick();
        check("wake no req", {15'd0, int_req}, 16'd0);
        if_wr = 1; if_wdata = 0; tick();
        check("wake clr", {15'd0, wake}, 16'd0);

        // Request beats a simultaneous write of the same bit.
        if_wr = 1; if_wdata = 0; src_req = 5'b00010; tick();
        check("req over write", {8'h00, if_q}, 16'h00E2);

        // DI while requesting withdraws the request without clearing IF.
        ie_wr = 1; ie_wdata = 8'h1F; tick();
        reti = 1; tick();
        instr_boundary = 1; tick();
        ime_clr = 1; tick();
        check("di abort", {15'd0, int_req}, 16'd0);

        // Asynchronous reset in the middle of a request.
        reti = 1; tick();
        instr_boundary = 1; tick();
        check("pre rst req", {15'd0, int_req}, 16'd1);
        #3 rst = 1'b0;
        #1;
        model_reset();
        check("async rst req", {15'd0, int_req}, 16'd0);
        check("async rst clear", {15'd0, int_clear}, 16'd0);
        check("async rst if_q", {8'h00, if_q}, 16'h00E0);
        reset_tick();
        release_reset();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            src_req        = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            if_wr          = ($urandom_range(0, 15) == 0);
            if_wdata       = 5'($urandom);
            ie_wr          = ($urandom_range(0, 31) == 0);
            ie_wdata       = 8'($urandom);
            ime_set        = ($urandom_range(0, 9) == 0);
            ime_clr        = ($urandom_range(0, 19) == 0);
            reti           = ($urandom_range(0, 9) == 0);
            instr_boundary = ($urandom_range(0, 2) == 0);
            int_ack        = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state changes on posedge.
REQ-002 SHALL have: rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-003 SHALL have: src_req  input  5  one-cycle request pulses {joypad, serial, timer, lcdc, vblank}, bit0 = vblank.
REQ-004 SHALL have: if_wr  input  1 / if_wdata  input  5  CPU write strobe/data for IF (0xFF0F).
REQ-005 SHALL have: ie_wr  input  1 / ie_wdata  input  8  CPU write strobe/data for IE (0xFFFF).
REQ-006 SHALL have: if_q  output  8  {3'b111, IF[4:0]}; ie_q  output  8  IE[7:0].
REQ-007 SHALL have: ime_set  input  1  EI executed; ime_clr  input  1  DI executed; reti  input  1  RETI executed.
REQ-008 SHALL have: instr_boundary  input  1  one-cycle pulse at each CPU instruction end.
REQ-009 SHALL have: int_req  output  1  dispatch request to CPU; int_vector  output  16  ISR address; int_ack  input  1  CPU accepted.
REQ-010 SHALL have: int_clear  output  1  one-cycle pulse when the IF bit of the serviced source is cleared.
REQ-011 SHALL have: wake  output  1  HALT exit condition; ime_q  output  1  current IME.

Function
REQ-012 IF bit n SHALL set on the cycle after src_req[n]=1.
REQ-013 if_wr SHALL load IF from if_wdata; on the same bit in the same cycle, src_req set SHALL win over the write.
REQ-014 ie_wr SHALL load all 8 IE bits; only IE[4:0] SHALL participate in masking.
REQ-015 pending = IF & IE[4:0]; wake SHALL equal |pending combinationally, independent of IME.
REQ-016 ime_clr SHALL clear IME on the next edge; reti SHALL set IME on the next edge.
REQ-017 ime_set SHALL set an ei_pend flag; IME SHALL become 1 on the first instr_boundary strictly after the ime_set cycle (one-instruction delay).
REQ-018 ime_clr SHALL clear ei_pend; ime_clr and ime_set in the same cycle: ime_clr wins.
REQ-019 FSM states SHALL be IDLE, REQ, CLEAR.
REQ-020 IDLE->REQ when IME=1 and |pending and instr_boundary=1; winner = lowest set pending bit (vblank highest priority).
REQ-021 On IDLE->REQ, winning index SHALL be latched; int_vector = 16'h0040 + 8*index (0x40,0x48,0x50,0x58,0x60), stable throughout REQ.
REQ-022 int_req SHALL be 1 exactly while in REQ; later changes of IF/IE SHALL NOT alter the latched vector.
REQ-023 REQ->CLEAR on int_ack=1; on that edge IF[index] and IME SHALL clear, and ei_pend SHALL clear.
REQ-024 If src_req[index] coincides with the ack edge, IF[index] SHALL remain set (new request preserved).
REQ-025 REQ->IDLE without clearing IF when ime_clr=1 and int_ack=0 in the same cycle; ack wins if both are asserted.
REQ-026 In CLEAR, int_clear SHALL be 1 for exactly one cycle; CLEAR->IDLE unconditionally.
REQ-027 IDLE SHALL NOT re-enter REQ in the cycle after CLEAR (IME=0); nested service requires reti/ime_set.
REQ-028 int_ack outside REQ SHALL be ignored.

Reset
REQ-029 While rst=0: IF=0, IE=0, IME=0, ei_pend=0, state=IDLE, latched index=0.
REQ-030 Outputs at reset: int_req=0, int_clear=0, int_vector=16'h0040, wake=0, ime_q=0, if_q=8'hE0, ie_q=8'h00.
REQ-031 Reset assertion in REQ or CLEAR SHALL abort immediately with no int_clear pulse; deassertion SHALL be synchronized to clk.

Structure
REQ-032 Shared package SHALL hold int_src_t enum (VBLANK=0..JOYPAD=4), INT_VEC_BASE=16'h0040, INT_VEC_STRIDE=8, and intc_state_t enum.
REQ-033 Priority selection SHALL be a sub-module int_prio_enc (5-bit in, valid + 3-bit index out).

Verification
REQ-034 IME=1, IE=0x1F, src_req=5'b00101, instr_boundary -> int_req=1, int_vector=0x0040; ack -> IF=0x04, int_clear pulse, IME=0.
REQ-035 ime_set, then instr_boundary with pending timer -> no int_req that boundary; IME=1 after it; next boundary -> vector 0x0050.
REQ-036 In REQ (vector 0x0058), raise src_req[0] before ack -> vector stays 0x0058; after CLEAR, IF[0]=1, no REQ until reti.
REQ-037 IME=0, IE=0x10, src_req[4] -> wake=1, int_req stays 0; if_wr 0x00 -> wake=0.
REQ-038 if_wr data 0x00 coinciding with src_req[1] -> if_q=0xE2.
REQ-039 rst=0 asserted while int_req=1 -> int_req=0 asynchronously, no int_clear, if_q=0xE0.
